// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: NUM_REQ sources share the single register-file write port, one winner per cycle.
// Round-robin by default; define WB_FIXED_PRIORITY_EN for lowest-index-wins fixed priority.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           reg_write,
  output logic [ADDR_WIDTH-1:0]          write_addr,
  output logic [DATA_WIDTH-1:0]          writeback_data,
  output logic                           wb_pending
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]      w_grant_idx;
  logic                  w_found;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

`ifdef WB_FIXED_PRIORITY_EN
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[k]) begin
        w_found     = 1'b1;
        w_grant_idx = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W:0]   w_cand_wide;
  logic [IDX_W-1:0] w_cand;

  // Walk the requesters starting at r_rr_ptr, wrapping at NUM_REQ (not at a power of two).
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand_wide = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand_wide = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_cand_wide >= (IDX_W+1)'(NUM_REQ))
        w_cand_wide = w_cand_wide - (IDX_W+1)'(NUM_REQ);
      w_cand = w_cand_wide[IDX_W-1:0];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (w_cand == IDX_W'(i)) && req_valid[i]) begin
          w_found     = 1'b1;
          w_grant_idx = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      if (w_grant_idx == IDX_W'(NUM_REQ-1))
        r_rr_ptr <= '0;
      else
        r_rr_ptr <= w_grant_idx + IDX_W'(1);
    end
  end
`endif

  assign w_accept = w_found & ~reset;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = w_accept && (w_grant_idx == IDX_W'(gi));
    end
  endgenerate

  assign wb_pending = |(req_valid & ~req_ready);

  // Writes to x0 are accepted but dropped; address/data keep the last real write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write      <= 1'b0;
      write_addr     <= '0;
      writeback_data <= '0;
    end else begin
      reg_write <= w_accept && (w_sel_addr != '0);
      if (w_accept && (w_sel_addr != '0)) begin
        write_addr     <= w_sel_addr;
        writeback_data <= w_sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter (NUM_REQ=2, round-robin build) with a writeback scoreboard.
module tb_regfile_wb_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            reg_write;
  logic [AW-1:0]   write_addr;
  logic [DW-1:0]   writeback_data;
  logic            wb_pending;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .reg_write(reg_write),
    .write_addr(write_addr), .writeback_data(writeback_data), .wb_pending(wb_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  rdy;
    logic        pend;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  vec_t        vecs[12];
  wb_t         sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [4:0]  last_a = '0;
  logic [31:0] last_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    req_valid = v.v;
    req_addr  = {v.a1, v.a0};
    req_data  = {v.d1, v.d0};
  endtask

  // Expected write for the next cycle, derived from the table's expected grant.
  task automatic push_expect(input vec_t v);
    wb_t e;
    logic [4:0]  a;
    logic [31:0] d;
    e = '{1'b0, last_a, last_d};
    if (v.rdy != 2'b00) begin
      a = v.rdy[1] ? v.a1 : v.a0;
      d = v.rdy[1] ? v.d1 : v.d0;
      if (a != 5'd0) begin
        last_a = a;
        last_d = d;
        e = '{1'b1, a, d};
      end
    end
    sb_q.push_back(e);
  endtask

  initial begin
    wb_t e;
    vecs[0]  = '{2'b11, 5'd1, 5'd2, 32'h11, 32'h22, 2'b01, 1'b1};
    vecs[1]  = '{2'b11, 5'd4, 5'd2, 32'h44, 32'h22, 2'b10, 1'b1};
    vecs[2]  = '{2'b11, 5'd4, 5'd6, 32'h44, 32'h66, 2'b01, 1'b1};
    vecs[3]  = '{2'b10, 5'd0, 5'd6, 32'h0,  32'h66, 2'b10, 1'b0};
    vecs[4]  = '{2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  2'b00, 1'b0};
    vecs[5]  = '{2'b10, 5'd0, 5'd7, 32'h0,  32'hDEAD_BEEF, 2'b10, 1'b0};
    vecs[6]  = '{2'b01, 5'd0, 5'd0, 32'h1234, 32'h0, 2'b01, 1'b0};
    vecs[7]  = '{2'b11, 5'd3, 5'd3, 32'hA,  32'hB,  2'b10, 1'b1};
    vecs[8]  = '{2'b01, 5'd3, 5'd0, 32'hA,  32'h0,  2'b01, 1'b0};
    vecs[9]  = '{2'b10, 5'd0, 5'd8, 32'h0,  32'h88, 2'b10, 1'b0};
    vecs[10] = '{2'b11, 5'd3, 5'd3, 32'hA,  32'hB,  2'b01, 1'b1};
    vecs[11] = '{2'b10, 5'd0, 5'd3, 32'h0,  32'hB,  2'b10, 1'b0};

    // Reset held with both requesters valid: nothing granted, outputs cleared.
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {32'h22, 32'h11};
    #2;
    chk("reset_ready", req_ready, 2'b00);
    chk("reset_we", reg_write, 1'b0);
    chk("reset_addr", write_addr, 5'd0);
    chk("reset_data", writeback_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("ready[%0d]", i), req_ready, vecs[i].rdy);
      chk($sformatf("pending[%0d]", i), wb_pending, vecs[i].pend);
      push_expect(vecs[i]);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("we[%0d]", i), reg_write, e.we);
      chk($sformatf("addr[%0d]", i), write_addr, e.a);
      chk($sformatf("data[%0d]", i), writeback_data, e.d);
      $display("txn %0d: valid=%b ready=%b we=%b addr=%0d data=%h", i, vecs[i].v, req_ready, reg_write, write_addr, writeback_data);
    end

    // Accept, then reset pulse before the write retires: write cancelled, pointer back to 0.
    @(negedge clk);
    req_valid = 2'b01;
    req_addr  = {5'd0, 5'd9};
    req_data  = {32'h0, 32'h99};
    #1;
    chk("inflight_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    chk("inflight_we", reg_write, 1'b1);
    chk("inflight_addr", write_addr, 5'd9);
    $display("txn inflight: we=%b addr=%0d data=%h", reg_write, write_addr, writeback_data);
    #1;
    reset = 1'b1;
    #1;
    chk("cancel_we", reg_write, 1'b0);
    chk("cancel_addr", write_addr, 5'd0);
    chk("cancel_ready", req_ready, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {32'h22, 32'h11};
    #1;
    chk("post_reset_grant", req_ready, 2'b01);
    $display("txn post_reset: valid=%b ready=%b", req_valid, req_ready);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_we", reg_write, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
